// File: rtl/lut_sched_pkg.sv
// lut_sched_pkg: shared sizing constants and output state encoding for lut_sched
package lut_sched_pkg;
  localparam int NUM_REQ = 4;
  localparam int LUT_W = 8;
  localparam int ID_W = $clog2(NUM_REQ);
  typedef enum logic {EMPTY, FULL} out_state_t;
endpackage

// File: rtl/lut_sched_if.sv
// lut_sched_if: config, request and result handshake bundle for lut_sched
interface lut_sched_if #(
  parameter int NUM_REQ = lut_sched_pkg::NUM_REQ,
  parameter int LUT_W = lut_sched_pkg::LUT_W
);
  localparam int IW = $clog2(NUM_REQ);
  logic clk_en;
  logic cfg_we;
  logic [IW-1:0] cfg_id;
  logic [LUT_W-1:0] cfg_lut;
  logic [NUM_REQ-1:0] req_valid;
  logic [3*NUM_REQ-1:0] req_bits;
  logic [NUM_REQ-1:0] req_ready;
  logic out_valid;
  logic out_bit;
  logic [IW-1:0] out_id;
  logic out_ready;
  logic [15:0] eval_count;
  modport master (
    output clk_en, cfg_we, cfg_id, cfg_lut, req_valid, req_bits, out_ready,
    input req_ready, out_valid, out_bit, out_id, eval_count
  );
  modport slave (
    input clk_en, cfg_we, cfg_id, cfg_lut, req_valid, req_bits, out_ready,
    output req_ready, out_valid, out_bit, out_id, eval_count
  );
endinterface

// File: rtl/lut_sched_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant scanning upward from ptr
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         en,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_id,
  output logic         any
);
  always_comb begin
    gnt = '0;
    gnt_id = '0;
    // descending scan so the requester closest to ptr is written last and wins
    for (int j = N - 1; j >= 0; j--) begin
      logic [W-1:0] k;
      k = W'((int'(ptr) + j) % N);
      if (en && req[k]) begin
        gnt = '0;
        gnt[k] = 1'b1;
        gnt_id = k;
      end
    end
  end
  assign any = |gnt;
endmodule

// File: rtl/lut_sched.sv
// lut_sched: round-robin shared 3-input LUT evaluator with a single-entry result register
module lut_sched #(
  parameter int NUM_REQ = lut_sched_pkg::NUM_REQ,
  parameter int LUT_W = lut_sched_pkg::LUT_W
) (
  input logic CLK,
  input logic RESETN,
  lut_sched_if.slave bus
);
  import lut_sched_pkg::*;
  localparam int IW = $clog2(NUM_REQ);
  logic [LUT_W-1:0] tables [NUM_REQ];
  logic [IW-1:0] rr_ptr, gnt_id, out_id;
  logic [NUM_REQ-1:0] gnt;
  logic [2:0] sel;
  logic [15:0] eval_count;
  logic any, out_bit, slot_free;
  out_state_t state;
  assign slot_free = state == EMPTY || bus.out_ready;
  // table read uses the pre-edge value, so a same-cycle config write never alters this grant
  assign sel = bus.req_bits[3*gnt_id +: 3];
  rr_arbiter #(.N(NUM_REQ), .W(IW)) u_arb (
    .req(bus.req_valid),
    .ptr(rr_ptr),
    .en(bus.clk_en && RESETN && slot_free),
    .gnt(gnt),
    .gnt_id(gnt_id),
    .any(any)
  );
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      for (int i = 0; i < NUM_REQ; i++) tables[i] <= '0;
      rr_ptr <= '0;
      state <= EMPTY;
      out_bit <= 1'b0;
      out_id <= '0;
      eval_count <= '0;
    end else if (bus.clk_en) begin
      if (bus.cfg_we) tables[bus.cfg_id] <= bus.cfg_lut;
      if (any) begin
        rr_ptr <= gnt_id == IW'(NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
        state <= FULL;
        out_bit <= tables[gnt_id][sel];
        out_id <= gnt_id;
        eval_count <= eval_count + 16'd1;
      end else if (bus.out_ready) state <= EMPTY;
    end
  end
  assign bus.req_ready = gnt;
  assign bus.out_valid = state == FULL;
  assign bus.out_bit = out_bit;
  assign bus.out_id = out_id;
  assign bus.eval_count = eval_count;
endmodule
